// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/funct encodings, flag bit indices and FSM states for alu_mdu
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_mdu_iter.sv
// rtl/alu_mdu_iter.sv - iterative shift-add multiplier / restoring divider on operand magnitudes,
// one bit per cycle for WIDTH cycles, signs restored on the hi/lo outputs
module alu_mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             run, op_r, neg_lo, neg_hi, div0;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, q, m;
  logic             a_neg, b_neg, div_ok;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod;

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // acc holds the partial product (mul) or the running remainder (div); q the multiplier/quotient
  assign mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
  assign div_sh   = {acc, q[WIDTH-1]};
  assign div_ok   = div_sh >= {1'b0, m};
  assign div_diff = div_sh - {1'b0, m};

  assign prod = neg_lo ? -{acc, q} : {acc, q};
  assign done = run && (cnt == LAST);
  assign hi   = (op_r == MD_DIV) ? (neg_hi ? -acc : acc) : prod[2*WIDTH-1:WIDTH];
  assign lo   = (op_r == MD_DIV) ? (div0 ? '1 : (neg_lo ? -q : q)) : prod[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      op_r   <= MD_MUL;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      op_r   <= op;
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= a_neg;
      div0   <= (op == MD_DIV) && (b == '0);
      acc    <= '0;
      q      <= mag_a;
      m      <= mag_b;
    end else if (run) begin
      if (op_r == MD_DIV) begin
        acc <= div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], div_ok};
      end else begin
        {acc, q} <= {mul_sum, q[WIDTH-1:1]};
      end
      cnt <= cnt + CW'(1);
      if (cnt == LAST) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - EX-stage ALU with registered result, HI/LO mul/div and one-entry output buffer;
// ALU_FAST_MUL_EN selects a single-cycle multiplier (divide stays iterative)
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             busy
);

  state_t state, state_next;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic [5:0] opcode, funct;
  logic [SHAMT_W-1:0] shamt, shamt_v;
  logic signed [15:0] imm16;
  logic [WIDTH-1:0] imm_s, imm_z, sum_ab, diff_ab, sum_ai;
  logic ovf_add, ovf_sub, ovf_addi, lt_s, lt_u, lt_si, lt_ui;
  logic accept, is_md, md_div, md_sgn;
  logic [WIDTH-1:0] alu_res;
  logic [2:0] alu_flags;
  logic iter_start, iter_done;
  logic [WIDTH-1:0] iter_hi, iter_lo, md_hi, md_lo;
  logic unused_bits;

  assign opcode  = instruction[31:26];
  assign funct   = instruction[5:0];
  assign shamt   = instruction[6 +: SHAMT_W];
  assign shamt_v = reg_a[SHAMT_W-1:0];
  assign imm16   = instruction[15:0];
  assign imm_s   = WIDTH'(imm16);
  assign imm_z   = WIDTH'(instruction[15:0]);
  assign unused_bits = ^instruction[25:16];

  assign sum_ab   = reg_a + reg_b;
  assign diff_ab  = reg_a - reg_b;
  assign sum_ai   = reg_a + imm_s;
  assign ovf_add  = (reg_a[WIDTH-1] == reg_b[WIDTH-1]) && (sum_ab[WIDTH-1] != reg_a[WIDTH-1]);
  assign ovf_sub  = (reg_a[WIDTH-1] != reg_b[WIDTH-1]) && (diff_ab[WIDTH-1] != reg_a[WIDTH-1]);
  assign ovf_addi = (reg_a[WIDTH-1] == imm_s[WIDTH-1]) && (sum_ai[WIDTH-1] != reg_a[WIDTH-1]);
  assign lt_s     = $signed(reg_a) < $signed(reg_b);
  assign lt_u     = reg_a < reg_b;
  assign lt_si    = $signed(reg_a) < $signed(imm_s);
  assign lt_ui    = reg_a < imm_s;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_MUL) || (state == ST_DIV);

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    is_md     = 1'b0;
    md_div    = 1'b0;
    md_sgn    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:   alu_res = reg_b << shamt;
          FN_SRL:   alu_res = reg_b >> shamt;
          FN_SRA:   alu_res = $signed(reg_b) >>> shamt;
          FN_SLLV:  alu_res = reg_b << shamt_v;
          FN_SRLV:  alu_res = reg_b >> shamt_v;
          FN_SRAV:  alu_res = $signed(reg_b) >>> shamt_v;
          FN_MFHI:  alu_res = hi_r;
          FN_MFLO:  alu_res = lo_r;
          FN_MULT:  begin is_md = 1'b1; md_sgn = 1'b1; end
          FN_MULTU: is_md = 1'b1;
          FN_DIV:   begin is_md = 1'b1; md_div = 1'b1; md_sgn = 1'b1; end
          FN_DIVU:  begin is_md = 1'b1; md_div = 1'b1; end
          FN_ADD:   begin alu_res = sum_ab; alu_flags[FLAG_OVF] = ovf_add; end
          FN_ADDU:  alu_res = sum_ab;
          FN_SUB:   begin alu_res = diff_ab; alu_flags[FLAG_OVF] = ovf_sub; end
          FN_SUBU:  alu_res = diff_ab;
          FN_AND:   alu_res = reg_a & reg_b;
          FN_OR:    alu_res = reg_a | reg_b;
          FN_XOR:   alu_res = reg_a ^ reg_b;
          FN_NOR:   alu_res = ~(reg_a | reg_b);
          FN_SLT:   begin alu_res = WIDTH'(lt_s); alu_flags[FLAG_NEG] = lt_s; end
          FN_SLTU:  begin alu_res = WIDTH'(lt_u); alu_flags[FLAG_NEG] = lt_u; end
          default:  ;
        endcase
      end
      OP_ADDI:  begin alu_res = sum_ai; alu_flags[FLAG_OVF] = ovf_addi; end
      OP_ADDIU: alu_res = sum_ai;
      OP_SLTI:  begin alu_res = WIDTH'(lt_si); alu_flags[FLAG_NEG] = lt_si; end
      OP_SLTIU: begin alu_res = WIDTH'(lt_ui); alu_flags[FLAG_NEG] = lt_ui; end
      OP_ANDI:  alu_res = reg_a & imm_z;
      OP_ORI:   alu_res = reg_a | imm_z;
      OP_XORI:  alu_res = reg_a ^ imm_z;
      OP_LW, OP_SW: alu_res = sum_ai;
      OP_BEQ:   begin alu_res = diff_ab; alu_flags[FLAG_ZERO] = (reg_a == reg_b); end
      OP_BNE:   begin alu_res = diff_ab; alu_flags[FLAG_ZERO] = (reg_a != reg_b); end
      default:  ;
    endcase
  end

`ifdef ALU_FAST_MUL_EN
  logic md_mul;
  logic [2*WIDTH-1:0] fast_prod, ext_a, ext_b;

  assign ext_a = {{WIDTH{md_sgn & reg_a[WIDTH-1]}}, reg_a};
  assign ext_b = {{WIDTH{md_sgn & reg_b[WIDTH-1]}}, reg_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_mul    <= 1'b0;
      fast_prod <= '0;
    end else if (accept && is_md) begin
      md_mul    <= !md_div;
      fast_prod <= ext_a * ext_b;
    end
  end

  assign iter_start = accept && md_div;
  assign md_hi = md_mul ? fast_prod[2*WIDTH-1:WIDTH] : iter_hi;
  assign md_lo = md_mul ? fast_prod[WIDTH-1:0] : iter_lo;
`else
  assign iter_start = accept && is_md;
  assign md_hi = iter_hi;
  assign md_lo = iter_lo;
`endif

  alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iter_start),
    .sgn   (md_sgn),
    .op    (md_div),
    .a     (reg_a),
    .b     (reg_b),
    .done  (iter_done),
    .hi    (iter_hi),
    .lo    (iter_lo)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && is_md) state_next = md_div ? ST_DIV : ST_MUL;
`ifdef ALU_FAST_MUL_EN
      ST_MUL:  state_next = ST_DONE;
`else
      ST_MUL:  if (iter_done) state_next = ST_DONE;
`endif
      ST_DIV:  if (iter_done) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // DONE never overlaps an accept, so the buffer is free when a mul/div result lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hi_r      <= '0;
      lo_r      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      state <= state_next;
      if (state == ST_DONE) begin
        hi_r <= md_hi;
        lo_r <= md_lo;
      end
      if (accept && !is_md) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        flags     <= alu_flags;
      end else if (state == ST_DONE) begin
        out_valid <= 1'b1;
        result    <= md_lo;
        flags     <= '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - scoreboard bench for alu_mdu
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int SHAMT_W = 5;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = WIDTH + 1;
`endif
  localparam int DIV_LAT = WIDTH + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] instruction = '0;
  logic [WIDTH-1:0] reg_a = '0;
  logic [WIDTH-1:0] reg_b = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic [2:0] flags;
  logic busy;

  alu_mdu #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .reg_a(reg_a), .reg_b(reg_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_res_q[$];
  logic [2:0]  exp_flg_q[$];
  string       exp_tag_q[$];
  string       mon_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 15'h0, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 10'h0, imm};
  endfunction

  function automatic void ref_r(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [2:0] f);
    logic signed [32:0] s;
    r = '0;
    f = '0;
    case (fn)
      6'h20: begin s = $signed({a[31], a}) + $signed({b[31], b}); r = s[31:0]; f[0] = s[32] ^ s[31]; end
      6'h21: r = a + b;
      6'h22: begin s = $signed({a[31], a}) - $signed({b[31], b}); r = s[31:0]; f[0] = s[32] ^ s[31]; end
      6'h23: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; f[1] = r[0]; end
      6'h2B: begin r = (a < b) ? 32'd1 : 32'd0; f[1] = r[0]; end
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_res_q.size() == 0) begin
        check("unexpected_out", {31'h0, out_valid}, 64'h0);
      end else begin
        mon_tag = exp_tag_q.pop_front();
        check({mon_tag, "_res"}, result, exp_res_q.pop_front());
        check({mon_tag, "_flg"}, flags, exp_flg_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    instruction = ins;
    reg_a = a;
    reg_b = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input logic [2:0] f);
    exp_tag_q.push_back(tag);
    exp_res_q.push_back(r);
    exp_flg_q.push_back(f);
    send(ins, a, b);
  endtask

  task automatic md_wait(input string tag, input int lat);
    int n = 0;
    int ready_hi = 0;
    check({tag, "_busy"}, busy, 1);
    if (in_ready) ready_hi++;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (!out_valid && in_ready) ready_hi++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_inready_low"}, ready_hi, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_res_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_res_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [5:0] fns[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0] fn;
    logic [31:0] ra, rb, er;
    logic [2:0] ef;
    int hold_bad;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    issue("add_ovf",  rtype(FN_ADD, 0),  32'h7FFFFFFF, 32'h1, 32'h80000000, 3'b001);
    issue("addu",     rtype(FN_ADDU, 0), 32'h7FFFFFFF, 32'h1, 32'h80000000, 3'b000);
    issue("sub_ovf",  rtype(FN_SUB, 0),  32'h80000000, 32'h1, 32'h7FFFFFFF, 3'b001);
    issue("bne_eq",   itype(OP_BNE, 16'h0), 32'd5, 32'd5, 32'h0, 3'b000);
    issue("beq_eq",   itype(OP_BEQ, 16'h0), 32'd5, 32'd5, 32'h0, 3'b100);
    issue("beq_ne",   itype(OP_BEQ, 16'h0), 32'd5, 32'd6, 32'hFFFFFFFF, 3'b000);
    issue("bne_ne",   itype(OP_BNE, 16'h0), 32'd5, 32'd6, 32'hFFFFFFFF, 3'b100);
    issue("sltu",     rtype(FN_SLTU, 0), 32'h1, 32'hFFFFFFFF, 32'h1, 3'b010);
    issue("slt",      rtype(FN_SLT, 0),  32'h1, 32'hFFFFFFFF, 32'h0, 3'b000);
    issue("sra",      rtype(FN_SRA, 4),  32'h0, 32'h80000000, 32'hF8000000, 3'b000);
    issue("srl",      rtype(FN_SRL, 4),  32'h0, 32'h80000000, 32'h08000000, 3'b000);
    issue("srav",     rtype(FN_SRAV, 0), 32'd36, 32'h80000000, 32'hF8000000, 3'b000);
    issue("sllv",     rtype(FN_SLLV, 0), 32'd31, 32'h1, 32'h80000000, 3'b000);
    issue("xori",     itype(OP_XORI, 16'h8001), 32'hFFFF0000, 32'h0, 32'hFFFF8001, 3'b000);
    issue("andi",     itype(OP_ANDI, 16'h8000), 32'hFFFFFFFF, 32'h0, 32'h00008000, 3'b000);
    issue("addi_neg", itype(OP_ADDI, 16'hFFFF), 32'd10, 32'h0, 32'd9, 3'b000);
    issue("addi_ovf", itype(OP_ADDI, 16'h0001), 32'h7FFFFFFF, 32'h0, 32'h80000000, 3'b001);
    issue("addiu",    itype(OP_ADDIU, 16'h0001), 32'h7FFFFFFF, 32'h0, 32'h80000000, 3'b000);
    issue("slti",     itype(OP_SLTI, 16'hFFFE), 32'hFFFFFFFB, 32'h0, 32'h1, 3'b010);
    issue("sltiu",    itype(OP_SLTIU, 16'hFFFF), 32'd5, 32'h0, 32'h1, 3'b010);
    issue("lw",       itype(OP_LW, 16'hFFFC), 32'h1000, 32'h0, 32'h00000FFC, 3'b000);
    issue("sw",       itype(OP_SW, 16'h0010), 32'h1000, 32'h0, 32'h00001010, 3'b000);
    issue("undef_op", itype(6'h3F, 16'h1234), 32'd5, 32'd6, 32'h0, 3'b000);
    issue("undef_fn", rtype(6'h3F, 0), 32'd5, 32'd6, 32'h0, 3'b000);

    for (int i = 0; i < 16; i++) begin
      fn = fns[$urandom_range(0, 9)];
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      ref_r(fn, ra, rb, er, ef);
      issue($sformatf("rnd%0d_fn%0h", i, fn), rtype(fn, 0), ra, rb, er, ef);
    end
    drain();

    issue("mult", rtype(FN_MULT, 0), 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 3'b000);
    md_wait("mult", MUL_LAT);
    issue("mfhi_mult", rtype(FN_MFHI, 0), 32'h0, 32'h0, 32'hFFFFFFFF, 3'b000);
    issue("mflo_mult", rtype(FN_MFLO, 0), 32'h0, 32'h0, 32'hFFFFFFFA, 3'b000);

    issue("div0", rtype(FN_DIV, 0), 32'd7, 32'd0, 32'hFFFFFFFF, 3'b000);
    md_wait("div0", DIV_LAT);
    issue("mfhi_div0", rtype(FN_MFHI, 0), 32'h0, 32'h0, 32'd7, 3'b000);

    issue("divn", rtype(FN_DIV, 0), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 3'b000);
    md_wait("divn", DIV_LAT);
    issue("mfhi_divn", rtype(FN_MFHI, 0), 32'h0, 32'h0, 32'hFFFFFFFF, 3'b000);

    issue("divmin", rtype(FN_DIV, 0), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3'b000);
    md_wait("divmin", DIV_LAT);
    issue("mfhi_divmin", rtype(FN_MFHI, 0), 32'h0, 32'h0, 32'h0, 3'b000);

    issue("divu", rtype(FN_DIVU, 0), 32'd100, 32'd7, 32'd14, 3'b000);
    md_wait("divu", DIV_LAT);
    issue("mfhi_divu", rtype(FN_MFHI, 0), 32'h0, 32'h0, 32'd2, 3'b000);

    issue("multu", rtype(FN_MULTU, 0), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 3'b000);
    md_wait("multu", MUL_LAT);
    issue("mfhi_multu", rtype(FN_MFHI, 0), 32'h0, 32'h0, 32'hFFFFFFFE, 3'b000);
    drain();

    out_ready = 1'b0;
    issue("sll_hold", rtype(FN_SLL, 4), 32'h0, 32'h1, 32'h10, 3'b000);
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || result !== 32'h10 || in_ready) hold_bad++;
    end
    check("hold_stable", hold_bad, 0);
    check("hold_result", result, 32'h10);
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", in_ready, 1);
    issue("b2b_addu", rtype(FN_ADDU, 0), 32'd2, 32'd3, 32'd5, 3'b000);
    drain();

    send(rtype(FN_DIVU, 0), 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    check("rst_mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst_mid_no_result", out_valid, 0);
    issue("mfhi_after_rst", rtype(FN_MFHI, 0), 32'h0, 32'h0, 32'h0, 3'b000);
    issue("mflo_after_rst", rtype(FN_MFLO, 0), 32'h0, 32'h0, 32'h0, 3'b000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
